// File: rtl/truth_table_seq_pkg.sv
// truth_table_seq_pkg
// Shared definitions for the truth-table sweeper: the FSM state encoding,
// the function-bank index constants and the first illegal function index.
// No ports; imported by truth_table_seq and f1_bank.
package truth_table_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] F1A = 3'd0;
  localparam logic [2:0] F1B = 3'd1;
  localparam logic [2:0] F1C = 3'd2;
  localparam logic [2:0] F1D = 3'd3;
  localparam logic [2:0] F1E = 3'd4;

  // Any func_sel at or above this value has no function behind it.
  localparam logic [2:0] FUNC_ILLEGAL = 3'd5;

  localparam int NUM_FUNCS = 5;

endpackage

// File: rtl/truth_table_seq_f1_bank.sv
// f1_bank
// Purely combinational bank of the five three-input functions, all driven
// from the same x, y, z operands. Output bit k is the function whose index
// constant in truth_table_seq_pkg equals k.
//   x, y, z : operand bits ({x,y,z} forms the truth-table row index)
//   f       : 5-bit vector of function outputs, f[F1A] .. f[F1E]
module f1_bank
  import truth_table_seq_pkg::*;
(
  input  logic                 x,
  input  logic                 y,
  input  logic                 z,
  output logic [NUM_FUNCS-1:0] f
);

  always_comb begin
    f      = '0;
    f[F1A] = ~x & y & ~z;
    f[F1B] = x & y & z;
    f[F1C] = (~x | y) & ~z;
    f[F1D] = (x | ~y) & z;
    f[F1E] = y & ~z;
  end

endmodule

// File: rtl/truth_table_seq.sv
// truth_table_seq
// Sweeps all eight operand combinations through one selected function of
// the f1 bank, captures the resulting truth table and compares it against a
// golden table latched at start.
//   clk         : single clock, rising edge
//   rst_n       : synchronous active-low reset, priority over start
//   start       : sweep request, only looked at in IDLE
//   func_sel    : function index 0..4; 5..7 rejected with an err pulse
//   expect_bits : golden truth table, bit i = required f({x,y,z}=i)
//   xyz         : operands currently applied to the bank (0 outside SWEEP)
//   table_bits  : captured truth table, bit i = f(i); held in IDLE
//   busy        : high in SWEEP and DONE
//   done        : one-cycle pulse in the DONE state
//   match       : captured table equals latched golden table
//   err         : one-cycle pulse after a start with an illegal func_sel
// The table/expect ports carry a _bits suffix because "table" and "expect"
// are reserved words in SystemVerilog.
module truth_table_seq
  import truth_table_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] func_sel,
  input  logic [7:0] expect_bits,
  output logic [2:0] xyz,
  output logic [7:0] table_bits,
  output logic       busy,
  output logic       done,
  output logic       match,
  output logic       err
);

  state_t                 state;
  state_t                 state_next;
  logic   [2:0]           idx;
  logic   [2:0]           fsel_q;
  logic   [7:0]           exp_q;
  logic   [7:0]           table_next;
  logic   [NUM_FUNCS-1:0] fvec;
  logic                   accept;
  logic                   reject;

  f1_bank u_bank (
    .x (xyz[2]),
    .y (xyz[1]),
    .z (xyz[0]),
    .f (fvec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Start is only honoured in IDLE, so requests during SWEEP or DONE fall
  // through without effect.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    xyz        = 3'b000;
    accept     = 1'b0;
    reject     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (func_sel < FUNC_ILLEGAL) begin
            accept     = 1'b1;
            state_next = SWEEP;
          end else begin
            reject = 1'b1;
          end
        end
      end
      SWEEP: begin
        busy = 1'b1;
        xyz  = idx;
        if (idx == 3'd7) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Table with the current row's function output merged in.
  always_comb begin
    table_next      = table_bits;
    table_next[idx] = fvec[fsel_q];
  end

  // idx wraps to 0 on the last capture, so the DONE cycle never writes a
  // ninth entry. match is decided from the final table on that same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= '0;
      fsel_q     <= '0;
      exp_q      <= '0;
      table_bits <= '0;
      match      <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        fsel_q     <= func_sel;
        exp_q      <= expect_bits;
        idx        <= '0;
        table_bits <= '0;
        match      <= 1'b0;
      end else if (reject) begin
        err <= 1'b1;
      end else if (state == SWEEP) begin
        table_bits <= table_next;
        idx        <= idx + 3'd1;
        if (idx == 3'd7) match <= (table_next == exp_q);
      end
    end
  end

endmodule

// File: tb/tb_truth_table_seq.sv
// tb_truth_table_seq
// Directed bench for truth_table_seq. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle from the active edge.
module tb_truth_table_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] func_sel;
  logic [7:0] expect_bits;
  logic [2:0] xyz;
  logic [7:0] table_bits;
  logic       busy;
  logic       done;
  logic       match;
  logic       err;

  int checks;
  int errors;

  truth_table_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .func_sel    (func_sel),
    .expect_bits (expect_bits),
    .xyz         (xyz),
    .table_bits  (table_bits),
    .busy        (busy),
    .done        (done),
    .match       (match),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one sampling edge; returns at the falling edge of the
  // first cycle after acceptance.
  task automatic do_start(input logic [2:0] sel, input logic [7:0] exp_v);
    @(negedge clk);
    start       = 1'b1;
    func_sel    = sel;
    expect_bits = exp_v;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    func_sel = 3'd0;
    expect_bits = 8'hFF;
    repeat (3) @(negedge clk);
    checks++; if (xyz !== 3'd0)        begin errors++; $display("[TB] FAIL reset_xyz got %0h want 0", xyz); end
    checks++; if (table_bits !== 8'h00) begin errors++; $display("[TB] FAIL reset_table got %0h want 00", table_bits); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("[TB] FAIL reset_done got %0b want 0", done); end
    checks++; if (match !== 1'b0)      begin errors++; $display("[TB] FAIL reset_match got %0b want 0", match); end
    checks++; if (err !== 1'b0)        begin errors++; $display("[TB] FAIL reset_err got %0b want 0", err); end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL post_reset_busy got %0b want 0", busy); end
  endtask

  task automatic test_sweep_f1a();
    do_start(3'd0, 8'h04);
    for (int k = 0; k < 8; k++) begin
      checks++; if (xyz !== 3'(k)) begin errors++; $display("[TB] FAIL f1a_xyz step %0d got %0d want %0d", k, xyz, k); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL f1a_busy step %0d got %0b want 1", k, busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL f1a_early_done step %0d got %0b want 0", k, done); end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1)        begin errors++; $display("[TB] FAIL f1a_done_cycle9 got %0b want 1", done); end
    checks++; if (table_bits !== 8'h04) begin errors++; $display("[TB] FAIL f1a_table got %0h want 04", table_bits); end
    checks++; if (match !== 1'b1)       begin errors++; $display("[TB] FAIL f1a_match got %0b want 1", match); end
    checks++; if (xyz !== 3'd0)         begin errors++; $display("[TB] FAIL f1a_done_xyz got %0d want 0", xyz); end
    @(negedge clk);
    checks++; if (done !== 1'b0)        begin errors++; $display("[TB] FAIL f1a_done_width got %0b want 0", done); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL f1a_idle_busy got %0b want 0", busy); end
    checks++; if (table_bits !== 8'h04) begin errors++; $display("[TB] FAIL f1a_table_hold got %0h want 04", table_bits); end
    checks++; if (match !== 1'b1)       begin errors++; $display("[TB] FAIL f1a_match_hold got %0b want 1", match); end
  endtask

  task automatic test_all_funcs();
    logic [7:0] want [1:4];
    want[1] = 8'h80;
    want[2] = 8'h45;
    want[3] = 8'hA2;
    want[4] = 8'h44;
    for (int s = 1; s <= 4; s++) begin
      int n = 0;
      do_start(3'(s), want[s]);
      while (!done && n < 20) begin
        @(negedge clk);
        n++;
      end
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL func%0d_done_timeout got %0b want 1", s, done); end
      checks++; if (n != 8) begin errors++; $display("[TB] FAIL func%0d_latency got %0d want 8", s, n); end
      checks++; if (table_bits !== want[s]) begin errors++; $display("[TB] FAIL func%0d_table got %0h want %0h", s, table_bits, want[s]); end
      checks++; if (match !== 1'b1) begin errors++; $display("[TB] FAIL func%0d_match got %0b want 1", s, match); end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    // Previous sweep left table=44 and match=1.
    @(negedge clk);
    start    = 1'b1;
    func_sel = 3'd6;
    expect_bits = 8'h00;
    @(negedge clk);
    start = 1'b0;
    checks++; if (err !== 1'b1)         begin errors++; $display("[TB] FAIL illegal_err got %0b want 1", err); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL illegal_busy got %0b want 0", busy); end
    checks++; if (table_bits !== 8'h44) begin errors++; $display("[TB] FAIL illegal_table got %0h want 44", table_bits); end
    checks++; if (match !== 1'b1)       begin errors++; $display("[TB] FAIL illegal_match got %0b want 1", match); end
    @(negedge clk);
    checks++; if (err !== 1'b0)         begin errors++; $display("[TB] FAIL illegal_err_width got %0b want 0", err); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL illegal_stays_idle got %0b want 0", busy); end
  endtask

  task automatic test_mismatch();
    int n = 0;
    do_start(3'd3, 8'hA3);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (done !== 1'b1)        begin errors++; $display("[TB] FAIL mismatch_done_timeout got %0b want 1", done); end
    checks++; if (table_bits !== 8'hA2) begin errors++; $display("[TB] FAIL mismatch_table got %0h want A2", table_bits); end
    checks++; if (match !== 1'b0)       begin errors++; $display("[TB] FAIL mismatch_match got %0b want 0", match); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    do_start(3'd2, 8'h45);
    // Cycle c counts falling edges after acceptance; xyz=4 in cycle 5,
    // DONE in cycle 9.
    for (int c = 1; c <= 16; c++) begin
      if (c == 5) begin
        checks++; if (xyz !== 3'd4) begin errors++; $display("[TB] FAIL b2b_xyz4 got %0d want 4", xyz); end
      end
      if (c == 9) begin
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done_cycle9 got %0b want 1", done); end
        checks++; if (table_bits !== 8'h45) begin errors++; $display("[TB] FAIL b2b_table got %0h want 45", table_bits); end
        checks++; if (match !== 1'b1) begin errors++; $display("[TB] FAIL b2b_match got %0b want 1", match); end
      end
      if (c == 10) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_start_ignored busy got %0b want 0", busy); end
      end
      if (done) dones++;
      if (c == 5 || c == 9) begin
        start       = 1'b1;
        func_sel    = 3'd0;
        expect_bits = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (dones != 1) begin errors++; $display("[TB] FAIL b2b_done_count got %0d want 1", dones); end
    checks++; if (table_bits !== 8'h45) begin errors++; $display("[TB] FAIL b2b_table_final got %0h want 45", table_bits); end
  endtask

  task automatic test_reset_mid_sweep();
    int n = 0;
    int dones = 0;
    do_start(3'd4, 8'h44);
    repeat (5) @(negedge clk);
    checks++; if (xyz !== 3'd5) begin errors++; $display("[TB] FAIL midrst_xyz5 got %0d want 5", xyz); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL midrst_busy got %0b want 0", busy); end
    checks++; if (table_bits !== 8'h00) begin errors++; $display("[TB] FAIL midrst_table got %0h want 00", table_bits); end
    checks++; if (xyz !== 3'd0)         begin errors++; $display("[TB] FAIL midrst_xyz got %0d want 0", xyz); end
    checks++; if (match !== 1'b0)       begin errors++; $display("[TB] FAIL midrst_match got %0b want 0", match); end
    for (int c = 0; c < 10; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checks++; if (dones != 0) begin errors++; $display("[TB] FAIL midrst_no_done got %0d pulses want 0", dones); end
    do_start(3'd1, 8'h80);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (done !== 1'b1)        begin errors++; $display("[TB] FAIL midrst_restart_timeout got %0b want 1", done); end
    checks++; if (n != 8)               begin errors++; $display("[TB] FAIL midrst_restart_latency got %0d want 8", n); end
    checks++; if (table_bits !== 8'h80) begin errors++; $display("[TB] FAIL midrst_restart_table got %0h want 80", table_bits); end
    checks++; if (match !== 1'b1)       begin errors++; $display("[TB] FAIL midrst_restart_match got %0b want 1", match); end
    @(negedge clk);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    func_sel    = 3'd0;
    expect_bits = 8'h00;
    test_reset();
    test_sweep_f1a();
    test_all_funcs();
    test_illegal();
    test_mismatch();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
